mem_line_master: RTL and testbench
==================================

MEM_LINE_MASTER -- requirements
Module: mem_line_master

Interface
REQ-001 Parameters SHALL be: ADDR_LEN, default 11, word-address width of memory port; LINE_LEN, default 3, log2 words per line (N = 1<<LINE_LEN); LINE_LEN < ADDR_LEN is required.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  requester has an operation pending.
REQ-005 req_ready  output  1  block idle and able to accept an operation.
REQ-006 req_op  input  2  operation: 0 READ (fill), 1 WRITE (writeback), 2 WB_FILL (writeback then fill), 3 reserved.
REQ-007 rd_line  input  ADDR_LEN-LINE_LEN  line address to fill.
REQ-008 wb_line  input  ADDR_LEN-LINE_LEN  line address to write back.
REQ-009 wr_word_idx  output  LINE_LEN  index of line word being written this cycle.
REQ-010 wr_word  input  32  requester's line word at wr_word_idx, same cycle (combinational lookup).
REQ-011 rd_word_valid  output  1  rd_word/rd_word_idx carry a filled word this cycle.
REQ-012 rd_word_idx  output  LINE_LEN  index of the filled word.
REQ-013 rd_word  output  32  filled word data.
REQ-014 done  output  1  one-cycle pulse: operation complete.
REQ-015 mem_addr  output  ADDR_LEN  memory word address.
REQ-016 mem_wr_req  output  1  memory write strobe.
REQ-017 mem_wr_data  output  32  memory write data.
REQ-018 mem_rd_data  input  32  memory read data; valid the cycle after mem_addr is presented (1-cycle latency).

Function
REQ-019 States SHALL be IDLE, WR, RD, DRAIN, DONE; word counter cnt of LINE_LEN bits.
REQ-020 req_ready SHALL be 1 only in IDLE; acceptance = req_valid && req_ready at cycle T; op and both line addresses SHALL be latched at T.
REQ-021 Transitions at acceptance: WRITE/WB_FILL -> WR, READ -> RD; op 3 SHALL be ignored (stay IDLE, no done).
REQ-022 WR: mem_wr_req=1, mem_addr={wb_line_l, cnt}, wr_word_idx=cnt, mem_wr_data=wr_word; cnt 0..N-1 over N cycles (T+1..T+N); at cnt=N-1 -> DONE (WRITE) or RD with cnt=0 (WB_FILL).
REQ-023 RD: mem_wr_req=0, mem_addr={rd_line_l, cnt}; cnt 0..N-1 over N consecutive cycles; at cnt=N-1 -> DRAIN.
REQ-024 rd_word_valid SHALL be 1 exactly one cycle after each RD cycle, with rd_word=mem_rd_data and rd_word_idx=address index issued the previous cycle; N valid beats, no gaps, ascending index.
REQ-025 DRAIN: delivers last word (idx N-1), mem_wr_req=0, -> DONE.
REQ-026 DONE: done=1 for one cycle, -> IDLE; a new request is accepted no earlier than the cycle after DONE.
REQ-027 Latency: WRITE done at T+N+1; READ done at T+N+2; WB_FILL done at T+2N+2.
REQ-028 Outside WR, mem_wr_req SHALL be 0; outside RD, mem_addr value is don't-care but SHALL be 0 in IDLE.
REQ-029 req_valid/req_op changes while busy SHALL have no effect; wr_word is sampled only in WR.
REQ-030 cnt wrap N-1 -> 0 SHALL be the only exit condition from WR/RD; no partial lines.

Reset
REQ-031 rst=1 at any clock edge SHALL force IDLE, cnt=0, latched op/addresses=0, irrespective of current state, including mid-WR (remaining words not written) and mid-RD/DRAIN (no further rd_word_valid, no done).
REQ-032 While in reset and after it, outputs SHALL be: req_ready=1, mem_wr_req=0, mem_addr=0, rd_word_valid=0, done=0, rd_word_idx=0, wr_word_idx=0, rd_word=0.

Structure
REQ-033 Shared package mem_if_pkg SHALL hold the op encoding enum (OP_READ, OP_WRITE, OP_WB_FILL), the state enum, and default ADDR_LEN/LINE_LEN constants.
REQ-034 Block SHALL be a single module, no sub-module; control outputs derived from registered state/cnt.

Verification
REQ-035 Bench memory model: 1-cycle read latency, preload word[a] = a ^ 32'h5A; ADDR_LEN=11, LINE_LEN=3.
REQ-036 READ rd_line=5 at T -> mem_addr 40..47 on T+1..T+8; rd_word_valid T+2..T+9, idx 0..7, rd_word 0x72,0x73,0x70,0x71,0x76,0x77,0x74,0x75; done T+10.
REQ-037 WRITE wb_line=2, wr_word=0xA000+idx -> mem_wr_req T+1..T+8, addresses 16..23 hold 0xA000..0xA007; done T+9; no rd_word_valid.
REQ-038 WB_FILL wb_line=3, rd_line=3, wr_word=0xB0+idx -> writes 24..31 then reads return 0xB0..0xB7 (read-after-write); done T+18.
REQ-039 rst asserted at T+4 of READ rd_line=1 -> next cycle IDLE, req_ready=1, no further rd_word_valid, no done; following READ completes normally.
REQ-040 req_valid held high continuously with req_op=3, then READ -> op 3 never busies or pulses done; back-to-back READs accepted one cycle after each done, req_ready=0 throughout each operation.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the line-transfer memory master: op encoding,
// controller state encoding and default geometry.
package mem_if_pkg;

    localparam int ADDR_LEN_DEF = 11;
    localparam int LINE_LEN_DEF = 3;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_WB_FILL = 2'd2,
        OP_RSVD    = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_line_master.sv
// Moves whole cache lines between a requester and a single-port word memory.
// Latency: WRITE done at T+N+1, READ at T+N+2, WB_FILL at T+2N+2 (N words/line).
// Backpressure: req_ready only in IDLE; memory side never stalls.
module mem_line_master
    import mem_if_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int LINE_LEN = LINE_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [ADDR_LEN-LINE_LEN-1:0] rd_line,
    input  logic [ADDR_LEN-LINE_LEN-1:0] wb_line,
    output logic [LINE_LEN-1:0]          wr_word_idx,
    input  logic [31:0]                  wr_word,
    output logic                         rd_word_valid,
    output logic [LINE_LEN-1:0]          rd_word_idx,
    output logic [31:0]                  rd_word,
    output logic                         done,
    output logic [ADDR_LEN-1:0]          mem_addr,
    output logic                         mem_wr_req,
    output logic [31:0]                  mem_wr_data,
    input  logic [31:0]                  mem_rd_data
);

    localparam int LINE_W = ADDR_LEN - LINE_LEN;

    state_t              state;
    op_t                 op_l;
    logic [LINE_LEN-1:0] cnt;
    logic [LINE_W-1:0]   rd_l;
    logic [LINE_W-1:0]   wb_l;
    logic                rd_vld;
    logic [LINE_LEN-1:0] rd_idx;
    logic                cnt_last;

    assign cnt_last = &cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_l   <= OP_READ;
            cnt    <= '0;
            rd_l   <= '0;
            wb_l   <= '0;
            rd_vld <= 1'b0;
            rd_idx <= '0;
        end else begin
            // Memory returns data one cycle after the address, so the beat
            // tag is simply the RD-cycle counter delayed by one.
            rd_vld <= (state == ST_RD);
            rd_idx <= (state == ST_RD) ? cnt : '0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid && op_t'(req_op) != OP_RSVD) begin
                        op_l  <= op_t'(req_op);
                        rd_l  <= rd_line;
                        wb_l  <= wb_line;
                        cnt   <= '0;
                        state <= (op_t'(req_op) == OP_READ) ? ST_RD : ST_WR;
                    end
                end
                ST_WR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt_last)
                        state <= (op_l == OP_WB_FILL) ? ST_RD : ST_DONE;
                end
                ST_RD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt_last)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready   = (state == ST_IDLE);
        done        = (state == ST_DONE);
        mem_wr_req  = (state == ST_WR);
        wr_word_idx = (state == ST_WR) ? cnt : '0;
        mem_wr_data = (state == ST_WR) ? wr_word : '0;
        mem_addr    = '0;
        if (state == ST_WR)
            mem_addr = {wb_l, cnt};
        else if (state == ST_RD)
            mem_addr = {rd_l, cnt};
    end

    assign rd_word_valid = rd_vld;
    assign rd_word_idx   = rd_idx;
    assign rd_word       = rd_vld ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_line_master.sv
// Directed bench for mem_line_master with a 1-cycle-latency word memory model.
module tb_mem_line_master;

    localparam int ADDR_LEN = 11;
    localparam int LINE_LEN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  rd_line;
    logic [7:0]  wb_line;
    logic [2:0]  wr_word_idx;
    logic [31:0] wr_word;
    logic        rd_word_valid;
    logic [2:0]  rd_word_idx;
    logic [31:0] rd_word;
    logic        done;
    logic [10:0] mem_addr;
    logic        mem_wr_req;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic [31:0] wr_base;
    logic [31:0] mem     [0:2047];
    logic [31:0] exp_mem [0:2047];
    logic [31:0] got_word [0:7];
    logic [31:0] rd5_tbl  [0:7];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_line_master #(.ADDR_LEN(ADDR_LEN), .LINE_LEN(LINE_LEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .rd_line(rd_line), .wb_line(wb_line),
        .wr_word_idx(wr_word_idx), .wr_word(wr_word),
        .rd_word_valid(rd_word_valid), .rd_word_idx(rd_word_idx), .rd_word(rd_word),
        .done(done), .mem_addr(mem_addr), .mem_wr_req(mem_wr_req),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    assign wr_word = wr_base + {29'b0, wr_word_idx};

    always @(posedge clk) begin
        if (mem_wr_req)
            mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one op from IDLE and check every cycle until the controller is idle again.
    task automatic run_op(input logic [1:0] op, input int rdl, input int wbl,
                          input logic [31:0] base, input bit hold);
        int  lat, rs, idx;
        bit  in_wr, in_rd, vld;
        lat = (op == 2'd1) ? 9 : (op == 2'd0) ? 10 : 18;
        rs  = (op == 2'd0) ? 0 : 8;
        chk("accept_rdy", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        rd_line   = rdl[7:0];
        wb_line   = wbl[7:0];
        wr_base   = base;
        @(negedge clk);
        if (hold) begin
            req_op  = 2'd3;
            rd_line = 8'hFF;
            wb_line = 8'hFF;
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 1; k <= lat; k++) begin
            in_wr = (op != 2'd0) && (k <= 8);
            in_rd = (op != 2'd1) && (k > rs) && (k <= rs + 8);
            vld   = (op != 2'd1) && (k > rs + 1) && (k <= rs + 9);
            idx   = k - rs - 2;
            chk("busy_rdy", {31'b0, req_ready}, 32'd0);
            chk("wr_req", {31'b0, mem_wr_req}, {31'b0, in_wr});
            chk("done", {31'b0, done}, {31'b0, k == lat});
            chk("rd_vld", {31'b0, rd_word_valid}, {31'b0, vld});
            if (in_wr) begin
                chk("wr_addr", {21'b0, mem_addr}, wbl * 8 + k - 1);
                chk("wr_idx", {29'b0, wr_word_idx}, k - 1);
                chk("wr_data", mem_wr_data, base + k - 1);
                exp_mem[wbl * 8 + k - 1] = base + k - 1;
            end
            if (in_rd)
                chk("rd_addr", {21'b0, mem_addr}, rdl * 8 + k - rs - 1);
            if (vld) begin
                chk("rd_idx", {29'b0, rd_word_idx}, idx);
                chk("rd_word", rd_word, exp_mem[rdl * 8 + idx]);
                got_word[idx] = rd_word;
            end
            @(negedge clk);
        end
        chk("idle_rdy", {31'b0, req_ready}, 32'd1);
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_addr", {21'b0, mem_addr}, 32'd0);
        chk("idle_vld", {31'b0, rd_word_valid}, 32'd0);
    endtask

    task automatic chk_rst_outs(input string tag);
        chk({tag, "_rdy"},   {31'b0, req_ready}, 32'd1);
        chk({tag, "_wr"},    {31'b0, mem_wr_req}, 32'd0);
        chk({tag, "_addr"},  {21'b0, mem_addr}, 32'd0);
        chk({tag, "_vld"},   {31'b0, rd_word_valid}, 32'd0);
        chk({tag, "_done"},  {31'b0, done}, 32'd0);
        chk({tag, "_ridx"},  {29'b0, rd_word_idx}, 32'd0);
        chk({tag, "_widx"},  {29'b0, wr_word_idx}, 32'd0);
        chk({tag, "_rword"}, rd_word, 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) begin
            mem[a]     = a ^ 32'h5A;
            exp_mem[a] = a ^ 32'h5A;
        end
        rd5_tbl = '{32'h72, 32'h73, 32'h70, 32'h71, 32'h76, 32'h77, 32'h74, 32'h75};
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0;
        rd_line = '0; wb_line = '0; wr_base = '0;
        repeat (3) @(negedge clk);
        chk_rst_outs("in_rst");
        rst = 1'b0;
        @(negedge clk);
        chk_rst_outs("post_rst");

        // READ line 5
        run_op(2'd0, 5, 0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++)
            chk("rd5_tbl", got_word[i], rd5_tbl[i]);

        // WRITE line 2
        run_op(2'd1, 0, 2, 32'hA000, 1'b0);
        for (int i = 0; i < 8; i++)
            chk("wb2_mem", mem[16 + i], 32'hA000 + i);

        // WB_FILL same line: reads must see the freshly written words
        run_op(2'd2, 3, 3, 32'hB0, 1'b0);
        for (int i = 0; i < 8; i++)
            chk("wbf_raw", got_word[i], 32'hB0 + i);

        // Reset in the middle of a READ
        req_valid = 1'b1; req_op = 2'd0; rd_line = 8'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_vld", {31'b0, rd_word_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_rst_outs("mid_rst");
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("aft_vld", {31'b0, rd_word_valid}, 32'd0);
            chk("aft_done", {31'b0, done}, 32'd0);
            chk("aft_rdy", {31'b0, req_ready}, 32'd1);
        end
        run_op(2'd0, 1, 0, 32'h0, 1'b0);

        // Reserved op held high must never start anything
        req_valid = 1'b1; req_op = 2'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("op3_rdy", {31'b0, req_ready}, 32'd1);
            chk("op3_done", {31'b0, done}, 32'd0);
            chk("op3_wr", {31'b0, mem_wr_req}, 32'd0);
        end

        // Back-to-back READs with req_valid held and inputs churning while busy
        run_op(2'd0, 4, 0, 32'h0, 1'b1);
        run_op(2'd0, 6, 0, 32'h0, 1'b1);
        run_op(2'd0, 7, 0, 32'h0, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
